// File: rtl/spi_slave_pkg.sv
// Shared types and default sizing for the SPI slave core and its synchronizers.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT      = 2'd1,
    ST_WAIT_DESEL = 2'd2
  } spi_state_e;

  localparam int DEF_FRAME_BITS  = 32;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with a configurable idle (reset) level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_p <= {STAGES{RST_VAL}};
    else       sync_p <= {sync_p[STAGES-2:0], d};
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave, MSB first, oversampled by clk. Define SPI_SLAVE_MISO_OE_EN
// to expose miso_oe for an external tristate buffer.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int FRAME_BITS  = DEF_FRAME_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic                  miso_oe,
`endif
  output logic                  miso,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_active,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam int              CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic sclk_p0, ss_n_p0, mosi_p0;
  logic sclk_p1, ss_n_p1;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_p0));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss_n (
    .clk(clk), .reset(reset), .d(ss_n), .q(ss_n_p0));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_p0));

  // Stage p1: one-cycle-delayed copies for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_p1 <= 1'b0;
      ss_n_p1 <= 1'b1;
    end else begin
      sclk_p1 <= sclk_p0;
      ss_n_p1 <= ss_n_p0;
    end
  end

  assign sclk_rise = sclk_p0 & ~sclk_p1;
  assign sclk_fall = ~sclk_p0 & sclk_p1;
  assign ss_fall   = ~ss_n_p0 & ss_n_p1;
  assign ss_rise   = ss_n_p0 & ~ss_n_p1;

  spi_state_e             state, state_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  tx_sh, rx_sh, hold_q;
  logic                   hold_full;
  logic                   frame_start, frame_done, frame_quit, tx_load;

  assign frame_start = (state == ST_IDLE) && ss_fall;
  assign frame_done  = (state == ST_SHIFT) && (bit_cnt == CNT_FULL);
  assign frame_quit  = (state == ST_SHIFT) && (bit_cnt != CNT_FULL) && ss_rise;
  assign tx_load     = tx_valid && !hold_full;
  assign tx_ready    = ~hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (ss_fall) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        // A completed frame wins over a simultaneous deselect
        if (bit_cnt == CNT_FULL) state_nxt = ST_WAIT_DESEL;
        else if (ss_rise)        state_nxt = ST_IDLE;
      end
      ST_WAIT_DESEL: if (ss_rise) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_active = (state == ST_SHIFT) || (state == ST_WAIT_DESEL);
    miso         = (state == ST_SHIFT) ? tx_sh[FRAME_BITS-1] : 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
    miso_oe      = (state == ST_SHIFT);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sh       <= '0;
      rx_sh       <= '0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      tx_underrun <= frame_start && !hold_full;
      frame_abort <= frame_quit;
      rx_valid    <= frame_done;
      if (frame_start) begin
        tx_sh     <= hold_full ? hold_q : '0;
        hold_full <= 1'b0;
        bit_cnt   <= '0;
      end else if (state == ST_SHIFT) begin
        if (sclk_rise && (bit_cnt != CNT_FULL)) begin
          rx_sh   <= {rx_sh[FRAME_BITS-2:0], mosi_p0};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        if (sclk_fall) tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
      end
      if (frame_done) rx_data <= rx_sh;
      // A load in the frame-start cycle lands after the consume above
      if (tx_load) begin
        hold_q    <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Randomized bench for spi_slave_core against a frame-level reference model.
module tb_spi_slave_core;

  localparam int FB = 32;

  logic          clk = 1'b0;
  logic          reset, sclk, ss_n, mosi, tx_valid;
  logic [FB-1:0] tx_data;
  logic          miso, tx_ready, rx_valid, frame_active, tx_underrun, frame_abort;
  logic [FB-1:0] rx_data;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic          miso_oe;
`endif

  spi_slave_core #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
`ifdef SPI_SLAVE_MISO_OE_EN
    .miso_oe(miso_oe),
`endif
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_active(frame_active),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rxv_n = 0, und_n = 0, abt_n = 0;

  // Reference model state: holding register and last received word
  logic          m_full;
  logic [FB-1:0] m_hold, m_rx;

  always @(negedge clk) begin
    if (rx_valid)    rxv_n <= rxv_n + 1;
    if (tx_underrun) und_n <= und_n + 1;
    if (frame_abort) abt_n <= abt_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [FB-1:0] w);
    chk("tx_ready_pre_load", {63'd0, tx_ready}, {63'd0, !m_full});
    @(posedge clk); #1;
    tx_data = w; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (!m_full) begin
      m_hold = w;
      m_full = 1'b1;
    end
  endtask

  task automatic sbit(input logic b, output logic m);
    mosi = b;
    repeat (8) @(posedge clk);
    #1 m = miso;
    sclk = 1'b1;
    repeat (8) @(posedge clk);
    #1 sclk = 1'b0;
  endtask

  // One ss_n window of nbits sclk cycles; co=1 pulses tx_valid exactly in the frame-start cycle
  task automatic frame(input string tag, input int nbits, input logic [FB-1:0] mw,
                       input bit co, input logic [FB-1:0] cw);
    logic [FB-1:0] got, exp_miso;
    logic          m, extra;
    bit            exp_un;
    int            rv0, un0, ab0;
    exp_miso = m_full ? m_hold : '0;
    exp_un   = !m_full;
    m_full   = 1'b0;
    if (co) begin
      m_hold = cw;
      m_full = 1'b1;
    end
    rv0 = rxv_n; un0 = und_n; ab0 = abt_n;
    got = '0; extra = 1'b0;
    @(posedge clk); #1 ss_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    if (co) begin
      tx_data = cw; tx_valid = 1'b1;
    end
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk({tag, "_active_start"}, {63'd0, frame_active}, 64'd1);
    for (int i = 0; i < nbits; i++) begin
      sbit((i < FB) ? mw[FB-1-i] : 1'($urandom_range(0, 1)), m);
      if (i < FB) got = {got[FB-2:0], m};
      else        extra = extra | m;
    end
    repeat (8) @(posedge clk); #1;
    chk({tag, "_active_end"}, {63'd0, frame_active}, 64'd1);
    ss_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk({tag, "_active_idle"}, {63'd0, frame_active}, 64'd1 - 64'd1);
    if (nbits >= FB) begin
      m_rx = mw;
      chk({tag, "_miso"}, {32'd0, got}, {32'd0, exp_miso});
      chk({tag, "_miso_extra"}, {63'd0, extra}, 64'd0);
    end else begin
      chk({tag, "_miso_part"}, {32'd0, got}, {32'd0, exp_miso >> (FB - nbits)});
    end
    chk({tag, "_rx_data"}, {32'd0, rx_data}, {32'd0, m_rx});
    chk({tag, "_rx_valid_n"}, 64'(rxv_n - rv0), (nbits >= FB) ? 64'd1 : 64'd0);
    chk({tag, "_abort_n"}, 64'(abt_n - ab0), (nbits < FB) ? 64'd1 : 64'd0);
    chk({tag, "_underrun_n"}, 64'(und_n - un0), exp_un ? 64'd1 : 64'd0);
    chk({tag, "_tx_ready"}, {63'd0, tx_ready}, {63'd0, !m_full});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},         {63'd0, miso},         64'd0);
    chk({tag, "_rx_valid"},     {63'd0, rx_valid},     64'd0);
    chk({tag, "_frame_active"}, {63'd0, frame_active}, 64'd0);
    chk({tag, "_underrun"},     {63'd0, tx_underrun},  64'd0);
    chk({tag, "_abort"},        {63'd0, frame_abort},  64'd0);
    chk({tag, "_tx_ready"},     {63'd0, tx_ready},     64'd1);
    chk({tag, "_rx_data"},      {32'd0, rx_data},      64'd0);
  endtask

  initial begin
    logic m;
    int   rv0, ab0, nb;
    reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    m_full = 1'b0; m_hold = '0; m_rx = '0;
    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("rst");
    reset = 1'b0;
    repeat (4) @(posedge clk); #1;

    load(32'hA5A5_1234);
    chk("tx_ready_full", {63'd0, tx_ready}, 64'd0);
    frame("basic", 32, 32'hDEAD_BEEF, 0, '0);

    frame("abort17", 17, $urandom, 0, '0);
    frame("underrun", 32, $urandom, 0, '0);

    load($urandom);
    frame("over40", 40, $urandom, 0, '0);

    // Reset in the middle of a frame
    load(32'h1357_2468);
    m_full = 1'b0;
    rv0 = rxv_n; ab0 = abt_n;
    @(posedge clk); #1 ss_n = 1'b0;
    repeat (12) @(posedge clk); #1;
    for (int i = 0; i < 10; i++) sbit(1'($urandom_range(0, 1)), m);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    m_rx = '0;
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (4) @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("midrst_rx_valid_n", 64'(rxv_n - rv0), 64'd0);
    chk("midrst_abort_n",    64'(abt_n - ab0), 64'd0);
    load(32'h0F0F_C3C3);
    frame("post_rst", 32, $urandom, 0, '0);

    // tx_valid landing in the frame-start cycle with an empty holding register
    frame("coincide", 32, $urandom, 1, 32'h8badf00d);
    frame("coincide_next", 32, $urandom, 0, '0);

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) load($urandom);
      if ($urandom_range(0, 3) == 0) load($urandom);
      case ($urandom_range(0, 3))
        0:       nb = $urandom_range(1, 31);
        1:       nb = $urandom_range(33, 38);
        default: nb = 32;
      endcase
      frame("rand", nb, $urandom, 0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 32, meaning bits per SPI frame, MSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sclk/ss_n/mosi (legal 2..3).
REQ-003 SHALL have port clk  input  1  sole clock; rising edge; frequency >= 8x sclk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 SHALL have port ss_n  input  1  slave select, active low, asynchronous.
REQ-007 SHALL have port mosi  input  1  serial data from master.
REQ-008 SHALL have port miso  output  1  serial data to master.
REQ-009 SHALL have port tx_data  input  FRAME_BITS  next word to transmit.
REQ-010 SHALL have port tx_valid  input  1  tx_data valid.
REQ-011 SHALL have port tx_ready  output  1  holding register empty; load on tx_valid & tx_ready.
REQ-012 SHALL have port rx_data  output  FRAME_BITS  last complete received word, held until next completion.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-014 SHALL have port frame_active  output  1  high in SHIFT and WAIT_DESEL states.
REQ-015 SHALL have port tx_underrun  output  1  one-cycle pulse, frame started with empty holding register.
REQ-016 SHALL have port frame_abort  output  1  one-cycle pulse, ss_n deasserted mid-frame.

Function
REQ-017 sclk, ss_n, mosi SHALL each pass an SYNC_STAGES flip-flop synchronizer; edges detected by comparing synced value with one further registered copy.
REQ-018 FSM states SHALL be IDLE, SHIFT, WAIT_DESEL.
REQ-019 IDLE: on synced ss_n falling edge SHALL load tx shifter from holding register (or all-zero if empty, pulsing tx_underrun), mark holding empty, clear bit counter, go SHIFT.
REQ-020 SHIFT: each synced sclk rising edge SHALL shift synced mosi into rx shifter LSB and increment counter; each falling edge SHALL shift tx shifter left by one.
REQ-021 When counter reaches FRAME_BITS SHALL copy rx shifter to rx_data, pulse rx_valid on the following cycle, go WAIT_DESEL.
REQ-022 WAIT_DESEL: further sclk edges SHALL be ignored and miso held at 0; synced ss_n rising edge SHALL go IDLE.
REQ-023 SHIFT with synced ss_n rising before counter reaches FRAME_BITS SHALL pulse frame_abort, discard rx shifter, leave rx_data unchanged, go IDLE.
REQ-024 miso SHALL equal tx shifter MSB in SHIFT, 0 otherwise; first bit valid before first sclk rising edge.
REQ-025 tx_ready SHALL be high whenever holding register empty; tx_valid with tx_ready low SHALL be ignored.
REQ-026 tx load and frame-start consume in same cycle: consume SHALL take the old content (empty -> underrun) and the new word SHALL be stored for the next frame.
REQ-027 Counter width SHALL be clog2(FRAME_BITS+1); no wrap inside a frame.

Reset
REQ-028 reset SHALL force IDLE, clear shifters, counter, holding register, rx_data to 0; miso, rx_valid, frame_active, tx_underrun, frame_abort to 0; tx_ready to 1.
REQ-029 reset mid-frame SHALL discard the frame without rx_valid or frame_abort pulse; synchronizers reset to idle levels (sclk 0, ss_n 1, mosi 0).

Configuration
REQ-030 Macro SPI_SLAVE_MISO_OE_EN defined: SHALL add output miso_oe, high only in SHIFT, for external tristate; miso still per REQ-024.
REQ-031 Macro undefined: miso_oe SHALL not exist; miso driven continuously.

Structure
REQ-032 Package spi_slave_pkg SHALL hold FSM state enum and default FRAME_BITS/SYNC_STAGES constants.
REQ-033 One sub-module spi_sync (parameterised-depth single-bit synchronizer) SHALL be instantiated for sclk, ss_n, mosi.

Verification
REQ-034 tx 0xA5A5_1234 loaded, master sends 0xDEAD_BEEF (32 sclk) -> miso bits 0xA5A51234, rx_data 0xDEADBEEF, one rx_valid pulse.
REQ-035 No tx load, full frame -> tx_underrun one pulse, miso all 0, rx_valid still pulses.
REQ-036 ss_n rises after 17 bits -> frame_abort one pulse, no rx_valid, rx_data keeps prior 0xDEADBEEF.
REQ-037 40 sclk cycles in one ss_n window -> one rx_valid after bit 32, bits 33-40 ignored, miso 0.
REQ-038 reset asserted at bit 10 -> all outputs reset values, tx_ready 1; next frame operates normally.
REQ-039 tx_valid coincident with ss_n fall, holding empty -> tx_underrun pulse; new word transmitted in next frame.
